// File: rtl/pc_seq_ctrl_if.sv
// Signal bundle between the PC sequencer and its surroundings: Run/Continue
// switches, IR/NZP, the execute-controller handshake and the datapath strobes.
interface pc_seq_ctrl_if;
    logic        Run;
    logic        Continue;
    logic [15:0] IR;
    logic [2:0]  NZP;
    logic        Exec_done;
    logic        Exec_req;
    logic        LD_MAR;
    logic        LD_MDR;
    logic        LD_IR;
    logic        LD_PC;
    logic        LD_REG;
    logic [1:0]  PCMUX;
    logic        ADDR1MUX;
    logic [1:0]  ADDR2MUX;
    logic        SR1MUX;
    logic        DRMUX;
    logic        GatePC;
    logic        GateMDR;
    logic        Mem_OE;
    logic        Halted;

    // Environment side: drives switches, IR/NZP and Exec_done.
    modport master (
        output Run, Continue, IR, NZP, Exec_done,
        input  Exec_req, LD_MAR, LD_MDR, LD_IR, LD_PC, LD_REG, PCMUX, ADDR1MUX,
               ADDR2MUX, SR1MUX, DRMUX, GatePC, GateMDR, Mem_OE, Halted
    );

    // Sequencer side.
    modport slave (
        input  Run, Continue, IR, NZP, Exec_done,
        output Exec_req, LD_MAR, LD_MDR, LD_IR, LD_PC, LD_REG, PCMUX, ADDR1MUX,
               ADDR2MUX, SR1MUX, DRMUX, GatePC, GateMDR, Mem_OE, Halted
    );
endinterface

// File: rtl/pc_seq_ctrl.sv
// SLC-3 program-counter sequencer: fetch cycle, local BR/JMP/JSR/PAUSE
// resolution, and delegation of all other opcodes to the execute controller.
module pc_seq_ctrl #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic              Clk,
    input  logic              Reset_al,
    pc_seq_ctrl_if.slave      bus,
    output logic [3:0]        dbg_state_o
);

    typedef enum logic [3:0] {
        S_HALTED    = 4'd0,
        S_FETCH1    = 4'd1,
        S_FETCH2    = 4'd2,
        S_FETCH3    = 4'd3,
        S_DECODE    = 4'd4,
        S_BR0       = 4'd5,
        S_BR1       = 4'd6,
        S_JMP0      = 4'd7,
        S_JSR0      = 4'd8,
        S_JSR1      = 4'd9,
        S_PAUSE     = 4'd10,
        S_PAUSE_REL = 4'd11,
        S_EXEC      = 4'd12
    } state_e;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       ben_q, ben_d;
    logic       jsr_off_q, jsr_off_d;

    assign dbg_state_o = state_q;

    always_ff @(posedge Clk or negedge Reset_al) begin
        if (!Reset_al) begin
            state_q   <= S_HALTED;
            cnt_q     <= 4'd0;
            ben_q     <= 1'b0;
            jsr_off_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ben_q     <= ben_d;
            jsr_off_q <= jsr_off_d;
        end
    end

    // Exec handshake: Exec_req is held high for the whole EXEC state; the
    // first clock edge that samples Exec_done=1 ends it, so Exec_req drops in
    // the following cycle. Exec_done is not looked at in any other state.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ben_d         = ben_q;
        jsr_off_d     = jsr_off_q;
        bus.Exec_req  = 1'b0;
        bus.LD_MAR    = 1'b0;
        bus.LD_MDR    = 1'b0;
        bus.LD_IR     = 1'b0;
        bus.LD_PC     = 1'b0;
        bus.LD_REG    = 1'b0;
        bus.PCMUX     = 2'b00;
        bus.ADDR1MUX  = 1'b0;
        bus.ADDR2MUX  = 2'b00;
        bus.SR1MUX    = 1'b0;
        bus.DRMUX     = 1'b0;
        bus.GatePC    = 1'b0;
        bus.GateMDR   = 1'b0;
        bus.Mem_OE    = 1'b0;
        bus.Halted    = 1'b0;

        case (state_q)
            S_HALTED: begin
                bus.Halted = 1'b1;
                if (bus.Run) state_d = S_FETCH1;
            end
            S_FETCH1: begin
                bus.GatePC = 1'b1;
                bus.LD_MAR = 1'b1;
                bus.LD_PC  = 1'b1;
                bus.PCMUX  = 2'b10;
                cnt_d      = 4'd0;
                state_d    = S_FETCH2;
            end
            S_FETCH2: begin
                bus.Mem_OE = 1'b1;
                cnt_d      = cnt_q + 4'd1;
                if (cnt_q == WAIT_LAST) begin
                    bus.LD_MDR = 1'b1;
                    state_d    = S_FETCH3;
                end
            end
            S_FETCH3: begin
                bus.GateMDR = 1'b1;
                bus.LD_IR   = 1'b1;
                state_d     = S_DECODE;
            end
            S_DECODE: begin
                // IR[11] is latched so JSR1 muxing stays a pure state decode.
                ben_d     = |(bus.IR[11:9] & bus.NZP);
                jsr_off_d = bus.IR[11];
                case (bus.IR[15:12])
                    4'b0000: state_d = S_BR0;
                    4'b1100: state_d = S_JMP0;
                    4'b0100: state_d = S_JSR0;
                    4'b1101: state_d = S_PAUSE;
                    default: state_d = S_EXEC;
                endcase
            end
            S_BR0: begin
                state_d = ben_q ? S_BR1 : S_FETCH1;
            end
            S_BR1: begin
                bus.LD_PC    = 1'b1;
                bus.PCMUX    = 2'b01;
                bus.ADDR2MUX = 2'b10;
                state_d      = S_FETCH1;
            end
            S_JMP0: begin
                bus.LD_PC    = 1'b1;
                bus.PCMUX    = 2'b01;
                bus.ADDR1MUX = 1'b1;
                bus.SR1MUX   = 1'b1;
                state_d      = S_FETCH1;
            end
            S_JSR0: begin
                bus.GatePC = 1'b1;
                bus.LD_REG = 1'b1;
                bus.DRMUX  = 1'b1;
                state_d    = S_JSR1;
            end
            S_JSR1: begin
                bus.LD_PC = 1'b1;
                bus.PCMUX = 2'b01;
                if (jsr_off_q) begin
                    bus.ADDR2MUX = 2'b11;
                end else begin
                    bus.ADDR1MUX = 1'b1;
                    bus.SR1MUX   = 1'b1;
                end
                state_d = S_FETCH1;
            end
            S_PAUSE: begin
                if (bus.Continue) state_d = S_PAUSE_REL;
            end
            S_PAUSE_REL: begin
                // Wait for release so a held switch runs exactly one PAUSE.
                if (!bus.Continue) state_d = S_FETCH1;
            end
            S_EXEC: begin
                bus.Exec_req = 1'b1;
                if (bus.Exec_done) state_d = S_FETCH1;
            end
            default: begin
                state_d = S_HALTED;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Bench for pc_seq_ctrl: instruction-level trace model feeding an expected
// queue of output words, checked every cycle, plus literal pins.
module tb_pc_seq_ctrl;

    localparam int MW = 2;

    // Output word layout: one bit/field per strobe, independent of the DUT.
    localparam logic [16:0] HALT     = 17'h00001;
    localparam logic [16:0] MEMOE    = 17'h00002;
    localparam logic [16:0] GMDR     = 17'h00004;
    localparam logic [16:0] GPC      = 17'h00008;
    localparam logic [16:0] DRM      = 17'h00010;
    localparam logic [16:0] SR1      = 17'h00020;
    localparam logic [16:0] A2_OFF9  = 17'h00080;
    localparam logic [16:0] A2_OFF11 = 17'h000C0;
    localparam logic [16:0] A1_BASE  = 17'h00100;
    localparam logic [16:0] PC_ADDER = 17'h00200;
    localparam logic [16:0] PC_INC   = 17'h00400;
    localparam logic [16:0] LDREG    = 17'h00800;
    localparam logic [16:0] LDPC     = 17'h01000;
    localparam logic [16:0] LDIR     = 17'h02000;
    localparam logic [16:0] LDMDR    = 17'h04000;
    localparam logic [16:0] LDMAR    = 17'h08000;
    localparam logic [16:0] EREQ     = 17'h10000;
    localparam logic [16:0] F1       = GPC | LDMAR | LDPC | PC_INC;

    logic        Clk = 1'b0;
    logic        Reset_al;
    logic [3:0]  dbg_state;
    logic [16:0] act;
    logic [16:0] e;
    logic [16:0] exp_q[$];
    logic        chk_en = 1'b0;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    pc_seq_ctrl_if bus ();

    pc_seq_ctrl #(.MEM_WAIT(MW)) dut (
        .Clk         (Clk),
        .Reset_al    (Reset_al),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc++;

    assign act = {bus.Exec_req, bus.LD_MAR, bus.LD_MDR, bus.LD_IR, bus.LD_PC,
                  bus.LD_REG, bus.PCMUX, bus.ADDR1MUX, bus.ADDR2MUX, bus.SR1MUX,
                  bus.DRMUX, bus.GatePC, bus.GateMDR, bus.Mem_OE, bus.Halted};

    always @(negedge Clk) begin
        if (chk_en) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL outputs cycle %0d: expected queue empty, actual %h", cyc, act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    bad++;
                    $display("FAIL outputs cycle %0d: actual %h required %h", cyc, act, e);
                end
            end
        end
    end

    task automatic lit(input string name, input logic [16:0] v);
        total++;
        if (act !== v) begin
            bad++;
            $display("FAIL %s: actual %h required %h", name, act, v);
        end
    endtask

    // Queue this cycle's expected outputs, then advance to just after the next edge.
    task automatic step(input logic [16:0] v);
        exp_q.push_back(v);
        @(posedge Clk);
        #1;
    endtask

    task automatic noise();
        bus.Run       = 1'($urandom_range(0, 1));
        bus.Exec_done = 1'($urandom_range(0, 1));
        bus.Continue  = 1'($urandom_range(0, 1));
        bus.IR        = 16'($urandom);
        bus.NZP       = 3'($urandom);
    endtask

    // Entered just after the edge that lands in FETCH1; leaves at the next FETCH1.
    task automatic run_instr(input logic [15:0] ir, input logic [2:0] nzp,
                             input int d, input int k, input int h, input bit le);
        noise();
        if (le) lit("fetch1", 17'h09408);
        step(F1);
        for (int i = 0; i < MW; i++) step((i == MW - 1) ? (MEMOE | LDMDR) : MEMOE);
        bus.IR  = ir;
        bus.NZP = nzp;
        step(GMDR | LDIR);
        step(17'h0);
        bus.NZP = 3'($urandom);
        case (ir[15:12])
            4'b0000: begin
                step(17'h0);
                if (|(ir[11:9] & nzp)) begin
                    if (le) lit("br1", 17'h01280);
                    step(LDPC | PC_ADDER | A2_OFF9);
                end
            end
            4'b1100: step(LDPC | PC_ADDER | A1_BASE | SR1);
            4'b0100: begin
                if (le) lit("jsr0", 17'h00818);
                step(GPC | LDREG | DRM);
                step(LDPC | PC_ADDER | (ir[11] ? A2_OFF11 : (A1_BASE | SR1)));
            end
            4'b1101: begin
                for (int i = 0; i < k; i++) begin
                    bus.Continue = 1'b0;
                    step(17'h0);
                end
                bus.Continue = 1'b1;
                step(17'h0);
                for (int i = 0; i < h; i++) step(17'h0);
                bus.Continue = 1'b0;
                step(17'h0);
            end
            default: begin
                bus.Exec_done = 1'b0;
                for (int i = 0; i < d; i++) step(EREQ);
                bus.Exec_done = 1'b1;
                step(EREQ);
            end
        endcase
    endtask

    initial begin
        logic [15:0] ir;
        Reset_al      = 1'b0;
        bus.Run       = 1'b0;
        bus.Continue  = 1'b0;
        bus.IR        = 16'h0000;
        bus.NZP       = 3'b000;
        bus.Exec_done = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        lit("reset", 17'h00001);
        Reset_al = 1'b1;
        chk_en   = 1'b1;
        repeat (4) step(HALT);
        bus.Run = 1'b1;
        step(HALT);

        // Asynchronous reset in the last FETCH2 cycle.
        step(F1);
        step(MEMOE);
        chk_en = 1'b0;
        lit("fetch2_last", 17'h04002);
        #2;
        Reset_al = 1'b0;
        #1;
        lit("async_reset", 17'h00001);
        repeat (2) @(posedge Clk);
        #1;
        Reset_al = 1'b1;
        bus.Run  = 1'b0;
        chk_en   = 1'b1;
        repeat (6) step(HALT);
        bus.Run = 1'b1;
        step(HALT);

        run_instr(16'h0A05, 3'b010, 0, 0, 0, 1'b1);
        run_instr(16'h0A05, 3'b100, 0, 0, 0, 1'b1);
        run_instr(16'h0005, 3'b111, 0, 0, 0, 1'b0);
        run_instr(16'hC080, 3'b000, 0, 0, 0, 1'b0);
        run_instr(16'h4805, 3'b000, 0, 0, 0, 1'b1);
        run_instr(16'h4080, 3'b000, 0, 0, 0, 1'b0);
        run_instr(16'h1021, 3'b000, 5, 0, 0, 1'b0);
        run_instr(16'h1021, 3'b000, 0, 0, 0, 1'b0);
        run_instr(16'hD000, 3'b000, 0, 0, 10, 1'b0);
        run_instr(16'h0E00, 3'b001, 0, 0, 0, 1'b1);

        for (int n = 0; n < 250; n++) begin
            ir = 16'($urandom);
            if ($urandom_range(0, 3) == 0) ir[15:12] = 4'b0000;
            run_instr(ir, 3'($urandom), $urandom_range(0, 4), $urandom_range(0, 3),
                      $urandom_range(0, 3), 1'b0);
        end
        chk_en = 1'b0;

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: actual %0d entries left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
- Control-flow sequencer for the SLC-3 program counter unit.
- Runs the fetch cycle MAR<-PC, PC<-PC+1, MDR<-M[MAR], IR<-MDR.
- Resolves BR/JMP/JSR/PAUSE locally by driving PC load/select and address-adder selects; hands every other opcode to the execute controller over a req/done handshake.
- Sits between the top-level Run/Continue switches and the PC, MAR/MDR, IR and register-file load strobes.

Parameters:
MEM_WAIT, 2, cycles Mem_OE is held before LD_MDR pulses (legal 1..15)

Ports:
Clk  input  1  system clock, rising edge
Reset_al  input  1  asynchronous active-low reset
Run  input  1  level; starts execution from HALTED
Continue  input  1  level; releases PAUSE
IR  input  16  current instruction register contents
NZP  input  3  condition codes {N,Z,P}
Exec_done  input  1  execute controller finished delegated instruction
Exec_req  output  1  delegate current IR to execute controller
LD_MAR  output  1  MAR load
LD_MDR  output  1  MDR load
LD_IR  output  1  IR load
LD_PC  output  1  PC register load
LD_REG  output  1  register file write
PCMUX  output  2  00 bus, 01 address adder, 10 PC+1
ADDR1MUX  output  1  0 PC, 1 BaseR
ADDR2MUX  output  2  00 zero, 01 off6, 10 off9, 11 off11
SR1MUX  output  1  1 selects IR[8:6] as BaseR
DRMUX  output  1  1 selects R7 as destination
GatePC  output  1  PC onto bus
GateMDR  output  1  MDR onto bus
Mem_OE  output  1  memory read enable
Halted  output  1  1 in HALTED state

Behaviour:
- All outputs are Moore decodes of state; no output depends combinationally on an input.
- Reset_al=0: state HALTED, wait counter 0, BEN 0. All outputs 0 except Halted=1. Effect is immediate, including mid-instruction.
- HALTED: Run=1 -> FETCH1; else stay.
- FETCH1: GatePC, LD_MAR, LD_PC, PCMUX=10 -> FETCH2; counter cleared.
  - MAR takes the old PC; PC becomes PC+1.
  - PC wraps 16'hFFFF -> 16'h0000 with no special handling.
- FETCH2: Mem_OE=1; counter increments each cycle.
  - LD_MDR=1 only in the cycle counter==MEM_WAIT-1, then -> FETCH3.
  - Total FETCH2 cycles = MEM_WAIT exactly.
- FETCH3: GateMDR, LD_IR -> DECODE.
- DECODE: latch BEN = |(IR[11:9] & NZP). Dispatch on IR[15:12]:
  - 0000 -> BR0
  - 1100 -> JMP0
  - 0100 -> JSR0
  - 1101 -> PAUSE
  - all others -> EXEC
- BR0: BEN=1 -> BR1; BEN=0 -> FETCH1 (not taken; nzp=000 is a never-taken branch).
- BR1: LD_PC, PCMUX=01, ADDR1MUX=0, ADDR2MUX=10 -> FETCH1.
- JMP0: LD_PC, PCMUX=01, ADDR1MUX=1, SR1MUX=1, ADDR2MUX=00 -> FETCH1.
- JSR0: GatePC, LD_REG, DRMUX=1 (R7<-PC) -> JSR1.
- JSR1: LD_PC, PCMUX=01, then -> FETCH1.
  - IR[11]=1: ADDR1MUX=0, ADDR2MUX=11.
  - IR[11]=0: ADDR1MUX=1, SR1MUX=1, ADDR2MUX=00.
- PAUSE: waits for Continue=1, then -> PAUSE_REL.
- PAUSE_REL: waits for Continue=0, then -> FETCH1.
  - Holding Continue high executes exactly one PAUSE.
- EXEC: Exec_req=1 until Exec_done sampled 1, then -> FETCH1.
  - Exec_req drops in the cycle after done is sampled.
  - Exec_done outside EXEC is ignored.
  - Exec_done high on the first EXEC cycle completes in 1 cycle.
- Run is sampled only in HALTED. Deasserting Run mid-program has no effect; only reset returns to HALTED.
- At most one LD_* strobe pair is active per state as listed. LD_PC and LD_IR are never simultaneous.

Test Plan:
1. Reset_al=0 mid-FETCH2, then 1 with Run=0 -> all outputs 0, Halted=1, held indefinitely; Mem_OE drops asynchronously.
2. PC=16'h3000, Run=1, MEM_WAIT=2 -> FETCH1 pulses LD_PC with PCMUX=10; Mem_OE high exactly 2 cycles; LD_MDR on 2nd; LD_IR next cycle; DECODE at cycle 5.
3. IR=16'h0A05 (BRnp), NZP=010 -> BR0 then FETCH1, no LD_PC. Same IR with NZP=100 -> BR1 pulses LD_PC, PCMUX=01, ADDR2MUX=10.
4. IR=16'h4805 (JSR) -> JSR0 LD_REG+DRMUX+GatePC; JSR1 LD_PC, ADDR2MUX=11, ADDR1MUX=0. IR=16'h4080 (JSRR R2) -> JSR1 ADDR1MUX=1, SR1MUX=1, ADDR2MUX=00.
5. IR=16'h1021 (ADD) -> Exec_req high; hold Exec_done=0 for 5 cycles (Exec_req stays 1); Exec_done=1 -> FETCH1 next cycle, Exec_req 0.
6. IR=16'hD000 (PAUSE), Continue held 1 for 10 cycles -> stays in PAUSE_REL; Continue=0 -> exactly one FETCH1, no second PAUSE skipped.
